fila_pedidos: RTL
=================

# fila_pedidos

Circular request queue that sits directly upstream of the SmartCargo movement control unit. It stores transport requests (pickup floor, delivery floor) entered by the operator and presents the current target stop to the movement FSM, expanding each request into two stops: origin first, then destination. It consumes the movement FSM's `shift` pulse to advance, and is cleared by `clearSuperRam`.

## Interface
- `DEPTH`, 8: number of request entries; must be a power of two, at least 2.
- `FLOOR_W`, 2: floor index width.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces the reset state below.
- `clear`  in  1  synchronous clear (driven by `clearSuperRam`); same effect as reset, one cycle later.
- `novo_pedido`  in  1  request button level; a request is taken on its rising edge only.
- `origem`  in  FLOOR_W  pickup floor, sampled on the cycle the edge is detected.
- `destino`  in  FLOOR_W  delivery floor, sampled with `origem`.
- `andarAtual`  in  FLOOR_W  current cabin floor, from the floor register.
- `shift`  in  1  one-cycle advance pulse from the movement FSM.
- `temDestino`  out  1  queue non-empty.
- `sobe`  out  1  `destinoAtual > andarAtual`.
- `chegouDestino`  out  1  `temDestino` and `destinoAtual == andarAtual`.
- `eh_origem`  out  1  current stop is the pickup stop of the head request.
- `destinoAtual`  out  FLOOR_W  floor of the current stop; 0 when empty.
- `ocupacao`  out  clog2(DEPTH)+1  number of stored requests.
- `cheia`  out  1  `ocupacao == DEPTH`.
- `pedido_rejeitado`  out  1  registered one-cycle pulse flagging a discarded request.

## Operation
- **State:**
  - Storage array of DEPTH entries {origem, destino}.
  - Head pointer `rd`, tail pointer `wr` (clog2(DEPTH) bits, natural wrap-around).
  - Count `ocupacao`.
  - Phase bit `fase` (0 = heading to origin, 1 = heading to destination).
  - Edge register `novo_d`.
- **Edge detection:** `push_req = novo_pedido & ~novo_d`. `novo_d <= novo_pedido` every cycle.
- **Push:** `push_req` is accepted when `ocupacao < DEPTH` (registered value) and `origem != destino`.
  - On accept: write entry at `wr`, `wr <= wr+1`.
  - On reject: store nothing; `pedido_rejeitado <= 1` for exactly the next cycle.
- **Shift:** ignored when empty.
  - If `fase == 0`: `fase <= 1`. Head stays; no pop.
  - If `fase == 1`: pop, i.e. `rd <= rd+1` and `fase <= 0`.
- **Simultaneous push and pop:** `ocupacao` is unchanged. A push while `cheia` is rejected even if a pop happens in the same cycle.
- **Outputs:** all combinational from registers plus `andarAtual`.
  - `destinoAtual = fase ? destino[rd] : origem[rd]`, forced to 0 when empty.
  - `eh_origem = temDestino & ~fase`.
  - `sobe` and `chegouDestino` are 0 when empty.
- **Clear and reset:**
  - `clear` has priority over push and shift in the same cycle.
  - Reset or clear sets `rd = wr = 0`, `ocupacao = 0`, `fase = 0`, `novo_d = 0`, `pedido_rejeitado = 0`.
  - Storage contents are don't-care.
- **Reset values of all outputs:**
  - `temDestino = 0`, `sobe = 0`, `chegouDestino = 0`, `eh_origem = 0`.
  - `destinoAtual = 0`, `ocupacao = 0`, `cheia = 0`, `pedido_rejeitado = 0`.
- **Reset mid-operation:** reset asserted at any point, including during a shift or push cycle, discards all requests. No partial write survives.

## Timing
- **Push latency:** edge detected in cycle N (`novo_pedido` high, `novo_d` low). Entry and count update at the end of N. `temDestino` and `destinoAtual` reflect the new head in N+1 if the queue was empty.
- **Held button:** a `novo_pedido` held high for many cycles produces exactly one request. A new request needs at least one low cycle first.
- **Shift latency:** a `shift` in cycle N changes `eh_origem`/`destinoAtual` in N+1. This matches the movement FSM's `shift_fila` → `aguarda_passageiro` sequence, so outputs are stable before `prox_pedido`.
- **Arrival checks:**
  - `chegouDestino` follows `andarAtual` combinationally, same cycle.
  - The movement FSM samples it in `checa_*`, after `registra_*` has updated the floor register.
- **Reject flag:** `pedido_rejeitado` rises the cycle after the rejected edge and lasts one cycle.

## Test plan
- **Reset and single request:**
  - Reset, then pulse `novo_pedido` with `origem=1`, `destino=3`, `andarAtual=0`.
  - Next cycle: `temDestino=1`, `eh_origem=1`, `destinoAtual=1`, `sobe=1`, `ocupacao=1`.
- **Two-stop expansion:**
  - With the request above and `andarAtual=1`: `chegouDestino=1`.
  - Pulse `shift`: next cycle `eh_origem=0`, `destinoAtual=3`, `sobe=1`, `ocupacao=1`.
  - Set `andarAtual=3`, pulse `shift`: next cycle `temDestino=0`, `ocupacao=0`, `destinoAtual=0`.
- **Held button and invalid request:**
  - Hold `novo_pedido` high 10 cycles with `origem=0`, `destino=2` → `ocupacao=1` only.
  - Release, then pulse with `origem=2`, `destino=2` → `pedido_rejeitado` high one cycle, `ocupacao` stays 1.
- **Full, wrap-around and simultaneous events:**
  - Push 8 valid requests → `cheia=1`.
  - A 9th push is rejected, including when it coincides with a popping `shift`, after which `ocupacao=7`.
  - Drain and refill past index 7; heads come out in FIFO order.
- **Clear priority:**
  - With 3 requests, assert `clear` together with `shift` and a push edge.
  - Next cycle: `ocupacao=0`, `fase=0`, `temDestino=0`, `pedido_rejeitado=0`.
- **Asynchronous reset mid-operation:**
  - Assert `reset` between clock edges while `fase=1` and `ocupacao=4`.
  - All outputs go to reset values immediately, before the next edge.
  - The first push after release behaves as in the first scenario.

Source files
------------

// File: rtl/fila_pedidos.sv
// rtl/fila_pedidos.sv - circular request queue feeding the movement FSM.
// Each request {origem, destino} is presented as two stops: origin first, then destination.
module fila_pedidos #(
  parameter int DEPTH   = 8,
  parameter int FLOOR_W = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       novo_pedido,
  input  logic [FLOOR_W-1:0]         origem,
  input  logic [FLOOR_W-1:0]         destino,
  input  logic [FLOOR_W-1:0]         andarAtual,
  input  logic                       shift,
  output logic                       temDestino,
  output logic                       sobe,
  output logic                       chegouDestino,
  output logic                       eh_origem,
  output logic [FLOOR_W-1:0]         destinoAtual,
  output logic [$clog2(DEPTH):0]     ocupacao,
  output logic                       cheia,
  output logic                       pedido_rejeitado
);

  localparam int AW = $clog2(DEPTH);

  logic [FLOOR_W-1:0] mem_origem  [DEPTH];
  logic [FLOOR_W-1:0] mem_destino [DEPTH];
  logic [AW-1:0]      rd;
  logic [AW-1:0]      wr;
  logic [AW:0]        count;
  logic               fase;
  logic               novo_d;

  logic push_req;
  logic push_ok;
  logic pop;
  logic empty;

  assign empty    = (count == '0);
  assign push_req = novo_pedido & ~novo_d;
  // Fullness uses the registered count, so a same-cycle pop never frees a slot for this push.
  assign push_ok  = push_req & ~clear & (count < (AW+1)'(DEPTH)) & (origem != destino);
  assign pop      = shift & ~clear & ~empty & fase;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd               <= '0;
      wr               <= '0;
      count            <= '0;
      fase             <= 1'b0;
      novo_d           <= 1'b0;
      pedido_rejeitado <= 1'b0;
    end else if (clear) begin
      rd               <= '0;
      wr               <= '0;
      count            <= '0;
      fase             <= 1'b0;
      novo_d           <= 1'b0;
      pedido_rejeitado <= 1'b0;
    end else begin
      novo_d           <= novo_pedido;
      pedido_rejeitado <= push_req & ~push_ok;
      if (push_ok) wr <= wr + 1'b1;
      if (shift && !empty) begin
        if (fase) begin
          rd   <= rd + 1'b1;
          fase <= 1'b0;
        end else begin
          fase <= 1'b1;
        end
      end
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset: pointers and count define which entries are valid.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_origem[wr]  <= origem;
      mem_destino[wr] <= destino;
    end
  end

  assign temDestino    = ~empty;
  assign destinoAtual  = empty ? '0 : (fase ? mem_destino[rd] : mem_origem[rd]);
  assign eh_origem     = temDestino & ~fase;
  assign sobe          = temDestino & (destinoAtual > andarAtual);
  assign chegouDestino = temDestino & (destinoAtual == andarAtual);
  assign ocupacao      = count;
  assign cheia         = (count == (AW+1)'(DEPTH));

endmodule
